// File: rtl/dmem_port_arbiter_if.sv
// Load path, store-buffer drain path and data-memory port of dmem_port_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_gnt;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_rvalid;

    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_wdata;
    logic              st_full;
    logic              st_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  ld_req, ld_addr, st_req, st_addr, st_wdata, st_full, mem_rdata,
        output ld_gnt, ld_rdata, ld_rvalid, st_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output ld_req, ld_addr, st_req, st_addr, st_wdata, st_full, mem_rdata,
        input  ld_gnt, ld_rdata, ld_rvalid, st_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between loads and store-buffer drain; DMEM_ARB_FWD_EN forwards same-word store data.
// Latency: store gnt +1 cycle; load gnt +1, ld_rvalid +3 cycles (forwarded load: rvalid +2). One op outstanding.
// Backpressure: requesters hold req/addr/data until their one-cycle gnt; nothing is granted outside IDLE.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    dmem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST     = 2'd1,
        LD     = 2'd2,
        LD_RSP = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef DMEM_ARB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic              fwd, fwd_nxt;

    logic              mem_en_r, mem_en_nxt;
    logic              mem_we_r, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt;
    logic              ld_gnt_r, ld_gnt_nxt;
    logic              st_gnt_r, st_gnt_nxt;
    logic              ld_rvalid_r, ld_rvalid_nxt;
    logic [DATA_W-1:0] ld_rdata_r, ld_rdata_nxt;
    logic              busy_r;

    logic              same_word;
    logic              promote;
    logic              conflict;
    logic              take_st;

    assign same_word = (bus.ld_addr[ADDR_W-1:2] == bus.st_addr[ADDR_W-1:2]);
    assign promote   = bus.st_req & (bus.st_full | (starve_cnt == STARVE_LIM));
    assign conflict  = bus.st_req & bus.ld_req & same_word;
    assign take_st   = promote | conflict | (bus.st_req & ~bus.ld_req);

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        fwd_nxt       = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr_r;
        mem_wdata_nxt = mem_wdata_r;
        ld_gnt_nxt    = 1'b0;
        st_gnt_nxt    = 1'b0;
        ld_rvalid_nxt = 1'b0;
        ld_rdata_nxt  = ld_rdata_r;

        unique case (state)
            IDLE: begin
                if (take_st) begin
                    state_nxt     = ST;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = bus.st_addr;
                    mem_wdata_nxt = bus.st_wdata;
                    st_gnt_nxt    = 1'b1;
                    // A promoted store never forwards; only a pure same-word conflict does.
                    if (FWD_EN && conflict && !promote) begin
                        fwd_nxt    = 1'b1;
                        ld_gnt_nxt = 1'b1;
                    end
                end else if (bus.ld_req) begin
                    state_nxt    = LD;
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = bus.ld_addr;
                    ld_gnt_nxt   = 1'b1;
                    if (bus.st_req && (starve_cnt != STARVE_LIM)) begin
                        starve_nxt = starve_cnt + 4'd1;
                    end
                end
            end
            ST: begin
                state_nxt  = IDLE;
                starve_nxt = 4'd0;
                if (fwd) begin
                    ld_rdata_nxt  = mem_wdata_r;
                    ld_rvalid_nxt = 1'b1;
                end
            end
            LD: begin
                state_nxt = LD_RSP;
            end
            LD_RSP: begin
                state_nxt     = IDLE;
                ld_rdata_nxt  = bus.mem_rdata;
                ld_rvalid_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            fwd         <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            ld_gnt_r    <= 1'b0;
            st_gnt_r    <= 1'b0;
            ld_rvalid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_nxt;
            fwd         <= fwd_nxt;
            mem_en_r    <= mem_en_nxt;
            mem_we_r    <= mem_we_nxt;
            mem_addr_r  <= mem_addr_nxt;
            mem_wdata_r <= mem_wdata_nxt;
            ld_gnt_r    <= ld_gnt_nxt;
            st_gnt_r    <= st_gnt_nxt;
            ld_rvalid_r <= ld_rvalid_nxt;
            busy_r      <= (state_nxt != IDLE);
        end
    end

    // Load data keeps its last value across reset, so this register has no reset term.
    always_ff @(posedge clk) begin
        if (reset_n && ld_rvalid_nxt) begin
            ld_rdata_r <= ld_rdata_nxt;
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.ld_gnt    = ld_gnt_r;
    assign bus.st_gnt    = st_gnt_r;
    assign bus.ld_rvalid = ld_rvalid_r;
    assign bus.ld_rdata  = ld_rdata_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a transaction-level model predicts grants and responses,
// a negedge monitor pops and compares whenever the DUT shows a gnt or ld_rvalid.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int K_LD  = 0;
    localparam int K_ST  = 1;
    localparam int K_FWD = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct { int cyc; int kind; logic [31:0] addr; logic [31:0] data; } gnt_t;
    typedef struct { int cyc; logic [31:0] data; } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   seen[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    logic [31:0] ref_mem[int];
    logic [31:0] phys_mem[int];
    logic [31:0] rd_next = 32'h0;

    // reference model state
    int m_free = 0;
    int m_busy_from = 0;
    int m_starve = 0;

    // requester state
    bit          ld_act = 1'b0, st_act = 1'b0, st_full_v = 1'b0;
    logic [31:0] ld_a = 32'h0, st_a = 32'h0, st_d = 32'h0;
    int          ld_hold = 0, st_hold = 0;

    always @(posedge clk) cyc++;

    function automatic int wd(input logic [31:0] a);
        return int'(a[31:2]);
    endfunction

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        if (!ref_mem.exists(w)) ref_mem[w] = init_word(w);
        return ref_mem[w];
    endfunction

    function automatic logic [31:0] phys_rd(input int w);
        if (!phys_mem.exists(w)) phys_mem[w] = init_word(w);
        return phys_mem[w];
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // memory behind the port: read data appears the cycle after the read, junk otherwise
    initial begin
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1 bus.mem_rdata = rd_next;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) begin
            rd_next = phys_rd(wd(bus.mem_addr));
        end else begin
            rd_next = $urandom;
            if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) phys_mem[wd(bus.mem_addr)] = bus.mem_wdata;
        end
    end

    task automatic grant_st(input bit f);
        gq.push_back('{cyc + 1, f ? K_FWD : K_ST, st_a, st_d});
        ref_mem[wd(st_a)] = st_d;
        m_starve    = 0;
        st_hold     = cyc + 1;
        m_busy_from = cyc + 1;
        m_free      = cyc + 2;
        if (f) begin
            ld_hold = cyc + 1;
            rq.push_back('{cyc + 2, st_d});
        end
    endtask

    // One arbitration decision from the priority rules, applied to what is driven this cycle.
    task automatic model_eval();
        bit fwd_en;
`ifdef DMEM_ARB_FWD_EN
        fwd_en = 1'b1;
`else
        fwd_en = 1'b0;
`endif
        if (cyc < m_free) return;
        if (st_act && (st_full_v || m_starve == STARVE_MAX)) grant_st(1'b0);
        else if (st_act && ld_act && wd(ld_a) == wd(st_a)) grant_st(fwd_en);
        else if (ld_act) begin
            gq.push_back('{cyc + 1, K_LD, ld_a, 32'h0});
            rq.push_back('{cyc + 3, ref_rd(wd(ld_a))});
            if (st_act && m_starve < STARVE_MAX) m_starve++;
            ld_hold     = cyc + 1;
            m_busy_from = cyc + 1;
            m_free      = cyc + 3;
        end else if (st_act) grant_st(1'b0);
    endtask

    task automatic drive();
        bus.ld_req   = ld_act;
        bus.ld_addr  = ld_a;
        bus.st_req   = st_act;
        bus.st_addr  = st_a;
        bus.st_wdata = st_d;
        bus.st_full  = st_act && st_full_v;
    endtask

    task automatic issue_ld(input logic [31:0] a);
        ld_act = 1'b1; ld_a = a; ld_hold = 1 << 30;
    endtask

    task automatic issue_st(input logic [31:0] a, input logic [31:0] d, input bit full);
        st_act = 1'b1; st_a = a; st_d = d; st_full_v = full; st_hold = 1 << 30;
    endtask

    // mode 0: no new requests, 1: starvation pattern, 2: random traffic
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ld_act && cyc > ld_hold) ld_act = 1'b0;
            if (st_act && cyc > st_hold) st_act = 1'b0;
            if (mode == 1) begin
                if (!ld_act) issue_ld(32'h100);
                if (!st_act) issue_st(32'h200, $urandom, 1'b0);
            end else if (mode == 2) begin
                if (!ld_act && $urandom_range(0, 2) == 0) issue_ld(32'h1000 + $urandom_range(0, 31));
                if (!st_act && $urandom_range(0, 2) == 0)
                    issue_st(32'h1000 + $urandom_range(0, 31), $urandom, $urandom_range(0, 3) == 0);
            end
            drive();
            model_eval();
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((gq.size() > 0 || rq.size() > 0 || ld_act || st_act) && k < 60) begin
            run(1, 0);
            k++;
        end
        tests++;
        if (gq.size() != 0 || rq.size() != 0 || ld_act || st_act) begin
            fails++;
            $display("FAIL drain: %0d grants and %0d responses outstanding, expected 0", gq.size(), rq.size());
        end
        run(2, 0);
    endtask

    // monitor
    always @(negedge clk) begin
        if (mon_en) begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL missing_gnt: grant absent, expected kind %0d at cycle %0d", gq[0].kind, gq[0].cyc);
                gq.delete(0);
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL missing_rvalid: response absent, expected 0x%08h at cycle %0d", rq[0].data, rq[0].cyc);
                rq.delete(0);
            end
            if (bus.ld_gnt || bus.st_gnt) begin
                if (gq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_gnt: ld_gnt=%0b st_gnt=%0b, expected no grant (cycle %0d)",
                             bus.ld_gnt, bus.st_gnt, cyc);
                end else begin
                    gnt_t e;
                    e = gq.pop_front();
                    check("gnt_cycle", 32'(cyc), 32'(e.cyc));
                    check("ld_gnt", 32'(bus.ld_gnt), 32'(e.kind != K_ST));
                    check("st_gnt", 32'(bus.st_gnt), 32'(e.kind != K_LD));
                    check("mem_en", 32'(bus.mem_en), 32'd1);
                    check("mem_we", 32'(bus.mem_we), 32'(e.kind != K_LD));
                    check("mem_addr", bus.mem_addr, e.addr);
                    if (e.kind != K_LD) check("mem_wdata", bus.mem_wdata, e.data);
                end
                seen.push_back(bus.st_gnt ? (bus.ld_gnt ? K_FWD : K_ST) : K_LD);
            end else begin
                check("idle_mem_en", 32'(bus.mem_en), 32'd0);
            end
            if (bus.ld_rvalid) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rvalid: data 0x%08h, expected no response (cycle %0d)", bus.ld_rdata, cyc);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                    check("ld_rdata", bus.ld_rdata, r.data);
                end
            end
            check("busy", 32'(bus.busy), 32'(cyc >= m_busy_from && cyc < m_free));
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_ld_gnt"}, 32'(bus.ld_gnt), 32'd0);
        check({tag, "_st_gnt"}, 32'(bus.st_gnt), 32'd0);
        check({tag, "_ld_rvalid"}, 32'(bus.ld_rvalid), 32'd0);
    endtask

    initial begin
        drive();
        ref_mem[wd(32'h40)]  = 32'hDEADBEEF;
        phys_mem[wd(32'h40)] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        check("reset_mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        // lone load
        issue_ld(32'h40);
        drain();

        // starvation: LLLLS twice
        seen.delete();
        run(28, 1);
        drain();
        tests++;
        if (seen.size() < 10) begin
            fails++;
            $display("FAIL starve_count: got %0d grants, expected at least 10", seen.size());
        end else begin
            for (int i = 0; i < 10; i++) check("starve_order", 32'(seen[i]), 32'((i % 5 == 4) ? K_ST : K_LD));
        end

        // full promotion
        seen.delete();
        issue_st(32'h300, 32'hA5A50001, 1'b1);
        issue_ld(32'h310);
        drain();
        check("full_first", 32'(seen.size() > 0 ? seen[0] : -1), 32'(K_ST));

        // same-word conflict
        seen.delete();
        issue_st(32'h84, 32'h12345678, 1'b0);
        issue_ld(32'h84);
        drain();
`ifdef DMEM_ARB_FWD_EN
        check("conflict_first", 32'(seen.size() > 0 ? seen[0] : -1), 32'(K_FWD));
`else
        check("conflict_first", 32'(seen.size() > 0 ? seen[0] : -1), 32'(K_ST));
`endif

        // reset in the LD_RSP cycle
        issue_ld(32'h500);
        run(2, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        ld_act = 1'b0;
        st_act = 1'b0;
        drive();
        gq.delete();
        rq.delete();
        m_starve = 0;
        m_free = cyc + 1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        issue_ld(32'h500);
        drain();

        // random traffic
        run(600, 2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
